// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the 9-bit-instruction core.
//   seq_state_t  : fetch sequencer states (IDLE, RUN, MEM_WAIT, DONE)
//   PC_W_DEFAULT : default program counter width
//   CNT_W_DEFAULT: default width of the retired-instruction counter
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int PC_W_DEFAULT  = 10;
    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        DONE     = 2'd3
    } seq_state_t;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the retired-instruction count. Only present
// when FETCH_SEQ_RETIRE_COUNT_EN is defined, so the default build carries no
// counter flops at all.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset, clears the count
//   inc   : add one this cycle (ignored once saturated)
//   clr   : synchronous clear, takes priority over inc
//   q     : current count
// ---------------------------------------------------------------------------
`ifdef FETCH_SEQ_RETIRE_COUNT_EN
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Saturate at all-ones rather than wrapping back to zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q = count_q;

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Program-counter sequencer between instruction memory and decode/control.
// Starts a program on start, steps the PC one instruction per cycle or jumps
// to the branch target, stalls on data-memory handshakes, and stops on halt
// or when sequential fetch would run off the end of instruction memory.
//
// Optional feature macro: FETCH_SEQ_RETIRE_COUNT_EN
//   defined   : retired counts retired instructions (saturating)
//   undefined : retired is tied to zero
//
// Ports:
//   clk, reset       : clock (rising edge), async active-high reset
//   start/start_addr : begin execution at start_addr (IDLE/DONE only)
//   halt             : current instruction is the halt opcode
//   branch_enable    : resolved branch decision for current instruction
//   branch_target    : absolute branch target
//   mem_access       : current instruction is a load or store
//   mem_ready        : data memory completes the access this cycle
//   pc               : address of current instruction
//   exec_en          : current instruction executes this cycle
//   mem_stall        : waiting on mem_ready
//   done             : program finished (held until next start)
//   pc_overflow      : sticky, program ended by PC wrap instead of halt
//   retired          : retired-instruction count
// ---------------------------------------------------------------------------
module fetch_sequencer
    import core_pkg::*;
#(
    parameter int PC_W  = PC_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic             halt,
    input  logic             branch_enable,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic [PC_W-1:0]  pc,
    output logic             exec_en,
    output logic             mem_stall,
    output logic             done,
    output logic             pc_overflow,
    output logic [CNT_W-1:0] retired
);

    seq_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            ovf_q, ovf_d;
    logic            pcAtMax;

    assign pcAtMax = &pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Sequential fetch past the last address ends the program instead of
    // wrapping; a branch from the last address is an ordinary jump.
    // Branches are ignored on memory instructions.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = start_addr;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = DONE;
                end else if (mem_access && !mem_ready) begin
                    state_d = MEM_WAIT;
                end else if (branch_enable && !mem_access) begin
                    pc_d = branch_target;
                end else if (pcAtMax) begin
                    state_d = DONE;
                    ovf_d   = 1'b1;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    if (pcAtMax) begin
                        state_d = DONE;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        pc_d    = pc_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        exec_en   = (state_q == RUN);
        mem_stall = (state_q == MEM_WAIT);
        done      = (state_q == DONE);
    end

    assign pc          = pc_q;
    assign pc_overflow = ovf_q;

`ifdef FETCH_SEQ_RETIRE_COUNT_EN
    logic retireNow;
    logic startAccept;

    // An instruction retires when it leaves RUN without stalling (halt
    // included) or when its pending memory access completes.
    assign retireNow = ((state_q == RUN) && (halt || !(mem_access && !mem_ready)))
                     || ((state_q == MEM_WAIT) && mem_ready);
    assign startAccept = start && ((state_q == IDLE) || (state_q == DONE));

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_retireCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (retireNow),
        .clr   (startAccept),
        .q     (retired)
    );
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer: a table of directed vectors, a few
// hand-written multi-cycle sequences (stall, overflow, restart, async reset)
// and a randomized run against a behavioural model.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int PC_W   = 10;
    localparam int CNT_W  = 16;
    localparam int PC_TOP = (1 << PC_W);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             start;
    logic [PC_W-1:0]  start_addr;
    logic             halt;
    logic             branch_enable;
    logic [PC_W-1:0]  branch_target;
    logic             mem_access;
    logic             mem_ready;
    logic [PC_W-1:0]  pc;
    logic             exec_en;
    logic             mem_stall;
    logic             done;
    logic             pc_overflow;
    logic [CNT_W-1:0] retired;

    int compared = 0;
    int failed   = 0;

    fetch_sequencer #(
        .PC_W  (PC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .start_addr    (start_addr),
        .halt          (halt),
        .branch_enable (branch_enable),
        .branch_target (branch_target),
        .mem_access    (mem_access),
        .mem_ready     (mem_ready),
        .pc            (pc),
        .exec_en       (exec_en),
        .mem_stall     (mem_stall),
        .done          (done),
        .pc_overflow   (pc_overflow),
        .retired       (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            st;
        logic [PC_W-1:0] sa;
        logic            h;
        logic            br;
        logic [PC_W-1:0] bt;
        logic            ma;
        logic            mr;
        logic [PC_W-1:0] ePc;
        logic            eExec;
        logic            eStall;
        logic            eDone;
        logic            eOvf;
        int              eRet;
    } vec_t;

    vec_t vecs[16];

    // Behavioural model: a program is either idle/finished, running, or
    // waiting on memory; the PC is tracked as a plain integer.
    bit mRunning, mWaiting, mFinished, mOvf;
    int mPc, mRet;

    function automatic vec_t mkVec(input logic st, input int sa, input logic h, input logic br,
                                   input int bt, input logic ma, input logic mr, input int ePc,
                                   input logic eExec, input logic eStall, input logic eDone,
                                   input logic eOvf, input int eRet);
        vec_t v;
        v.st = st; v.sa = PC_W'(sa); v.h = h; v.br = br; v.bt = PC_W'(bt);
        v.ma = ma; v.mr = mr; v.ePc = PC_W'(ePc); v.eExec = eExec; v.eStall = eStall;
        v.eDone = eDone; v.eOvf = eOvf; v.eRet = eRet;
        return v;
    endfunction

    function automatic logic [CNT_W-1:0] retExp(input int r);
`ifdef FETCH_SEQ_RETIRE_COUNT_EN
        return CNT_W'(r);
`else
        return (r == -1) ? '1 : '0;
`endif
    endfunction

    task automatic applyStimulus(input logic st, input logic [PC_W-1:0] sa, input logic h,
                                 input logic br, input logic [PC_W-1:0] bt,
                                 input logic ma, input logic mr);
        start = st; start_addr = sa; halt = h; branch_enable = br;
        branch_target = bt; mem_access = ma; mem_ready = mr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [PC_W-1:0] ePc, input logic eExec,
                               input logic eStall, input logic eDone, input logic eOvf,
                               input int eRet);
        logic [CNT_W-1:0] eR;
        eR = retExp(eRet);
        compared++;
        if (pc !== ePc || exec_en !== eExec || mem_stall !== eStall || done !== eDone
            || pc_overflow !== eOvf || retired !== eR) begin
            failed++;
            $display("[TB] FAIL %s: got pc=%h exec=%b stall=%b done=%b ovf=%b ret=%0d, expected pc=%h exec=%b stall=%b done=%b ovf=%b ret=%0d",
                     tag, pc, exec_en, mem_stall, done, pc_overflow, retired,
                     ePc, eExec, eStall, eDone, eOvf, eR);
        end
    endtask

    task automatic modelAdvance();
        if (mPc + 1 == PC_TOP) begin
            mRunning = 0; mFinished = 1; mOvf = 1;
        end else begin
            mPc = mPc + 1; mRunning = 1;
        end
    endtask

    task automatic modelRetire();
        if (mRet < CNT_MAX) mRet = mRet + 1;
    endtask

    task automatic modelStep(input logic st, input int sa, input logic h, input logic br,
                             input int bt, input logic ma, input logic mr);
        if (!mRunning && !mWaiting) begin
            if (st) begin
                mRunning = 1; mFinished = 0; mPc = sa; mOvf = 0; mRet = 0;
            end
        end else if (mWaiting) begin
            if (mr) begin
                modelRetire();
                mWaiting = 0;
                modelAdvance();
            end
        end else begin
            if (h) begin
                modelRetire();
                mRunning = 0; mFinished = 1;
            end else if (ma && !mr) begin
                mRunning = 0; mWaiting = 1;
            end else begin
                modelRetire();
                if (br && !ma) mPc = bt;
                else modelAdvance();
            end
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        start = 0; start_addr = '0; halt = 0; branch_enable = 0;
        branch_target = '0; mem_access = 0; mem_ready = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mRunning = 0; mWaiting = 0; mFinished = 0; mOvf = 0; mPc = 0; mRet = 0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic            rSt, rH, rBr, rMa, rMr;
        logic [PC_W-1:0] rSa, rBt;

        // pc, exec, stall, done, ovf, retired after each edge
        vecs[0]  = mkVec(1, 'h010, 0, 0, 'h000, 0, 0, 'h010, 1, 0, 0, 0, 0);
        vecs[1]  = mkVec(0, 'h000, 0, 0, 'h000, 0, 0, 'h011, 1, 0, 0, 0, 1);
        vecs[2]  = mkVec(0, 'h000, 0, 0, 'h000, 0, 0, 'h012, 1, 0, 0, 0, 2);
        vecs[3]  = mkVec(0, 'h000, 0, 0, 'h000, 0, 0, 'h013, 1, 0, 0, 0, 3);
        vecs[4]  = mkVec(0, 'h000, 1, 0, 'h000, 0, 0, 'h013, 0, 0, 1, 0, 4);
        vecs[5]  = mkVec(1, 'h003, 0, 0, 'h000, 0, 0, 'h003, 1, 0, 0, 0, 0);
        vecs[6]  = mkVec(0, 'h000, 0, 0, 'h000, 0, 0, 'h004, 1, 0, 0, 0, 1);
        vecs[7]  = mkVec(0, 'h000, 0, 0, 'h000, 0, 0, 'h005, 1, 0, 0, 0, 2);
        vecs[8]  = mkVec(0, 'h000, 0, 1, 'h020, 0, 0, 'h020, 1, 0, 0, 0, 3);
        vecs[9]  = mkVec(0, 'h000, 0, 1, 'h030, 1, 1, 'h021, 1, 0, 0, 0, 4);
        vecs[10] = mkVec(1, 'h1AB, 0, 0, 'h000, 0, 0, 'h022, 1, 0, 0, 0, 5);
        vecs[11] = mkVec(0, 'h000, 1, 0, 'h000, 0, 0, 'h022, 0, 0, 1, 0, 6);
        vecs[12] = mkVec(1, 'h004, 0, 0, 'h000, 0, 0, 'h004, 1, 0, 0, 0, 0);
        vecs[13] = mkVec(0, 'h000, 0, 0, 'h000, 0, 0, 'h005, 1, 0, 0, 0, 1);
        vecs[14] = mkVec(0, 'h000, 1, 1, 'h020, 0, 0, 'h005, 0, 0, 1, 0, 2);
        vecs[15] = mkVec(0, 'h000, 0, 1, 'h0AA, 0, 0, 'h005, 0, 0, 1, 0, 2);

        reset = 1'b1;
        start = 0; start_addr = '0; halt = 0; branch_enable = 0;
        branch_target = '0; mem_access = 0; mem_ready = 0;
        #2;
        checkOutput("resetState", 'h000, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].st, vecs[i].sa, vecs[i].h, vecs[i].br, vecs[i].bt,
                          vecs[i].ma, vecs[i].mr);
            checkOutput($sformatf("vec%0d", i), vecs[i].ePc, vecs[i].eExec, vecs[i].eStall,
                        vecs[i].eDone, vecs[i].eOvf, vecs[i].eRet);
        end

        $display("[TB] overflow and restart");
        applyStimulus(1, 'h3FE, 0, 0, 'h000, 0, 0);
        checkOutput("ovfStart", 'h3FE, 1, 0, 0, 0, 0);
        applyStimulus(0, 'h000, 0, 0, 'h000, 0, 0);
        checkOutput("ovfMax", 'h3FF, 1, 0, 0, 0, 1);
        applyStimulus(0, 'h000, 0, 0, 'h000, 0, 0);
        checkOutput("ovfWrap", 'h3FF, 0, 0, 1, 1, 2);
        applyStimulus(0, 'h000, 0, 0, 'h000, 0, 0);
        checkOutput("ovfSticky", 'h3FF, 0, 0, 1, 1, 2);
        applyStimulus(1, 'h040, 0, 0, 'h000, 0, 0);
        checkOutput("restartDone", 'h040, 1, 0, 0, 0, 0);
        applyStimulus(0, 'h000, 0, 1, 'h3FF, 0, 0);
        checkOutput("branchToMax", 'h3FF, 1, 0, 0, 0, 1);
        applyStimulus(0, 'h000, 0, 1, 'h007, 0, 0);
        checkOutput("branchFromMax", 'h007, 1, 0, 0, 0, 2);

        $display("[TB] memory stall and async reset");
        doReset();
        applyStimulus(1, 'h100, 0, 0, 'h000, 0, 0);
        checkOutput("memStart", 'h100, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 'h000, 0, 1, 'h055, 1, 0);
            checkOutput($sformatf("memWait%0d", i), 'h100, 0, 1, 0, 0, 0);
        end
        applyStimulus(0, 'h000, 0, 0, 'h000, 1, 1);
        checkOutput("memReady", 'h101, 1, 0, 0, 0, 1);
        applyStimulus(0, 'h000, 0, 0, 'h000, 1, 1);
        checkOutput("memZeroWait", 'h102, 1, 0, 0, 0, 2);
        applyStimulus(0, 'h000, 0, 0, 'h000, 1, 0);
        checkOutput("memWaitAgain", 'h102, 0, 1, 0, 0, 2);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("asyncReset", 'h000, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(0, 'h000, 0, 0, 'h000, 1, 1);
        checkOutput("idleAfterReset", 'h000, 0, 0, 0, 0, 0);

        $display("[TB] randomized run against model");
        doReset();
        for (int n = 0; n < 3000; n++) begin
            rSt = (!mRunning && !mWaiting) ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
            rSa = ($urandom_range(3) == 0) ? PC_W'(10'h3F0 + $urandom_range(15))
                                           : PC_W'($urandom);
            rH  = ($urandom_range(29) == 0);
            rBr = ($urandom_range(4) == 0);
            rBt = ($urandom_range(7) == 0) ? PC_W'(10'h3FF) : PC_W'($urandom);
            rMa = ($urandom_range(3) == 0);
            rMr = ($urandom_range(1) == 0);
            applyStimulus(rSt, rSa, rH, rBr, rBt, rMa, rMr);
            modelStep(rSt, int'(rSa), rH, rBr, int'(rBt), rMa, rMr);
            checkOutput($sformatf("rand%0d", n), PC_W'(mPc), mRunning, mWaiting, mFinished,
                        mOvf, mRet);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter sequencer for the 9-bit-instruction core; sits between instruction memory and the decode/control stage.
- Starts a program on `start`, then advances the PC one instruction per cycle, or takes the branch target when the control stage asserts branch enable.
- Stalls on data-memory handshakes and stops on halt or PC exhaustion.
- Generates the per-cycle execute enable that qualifies register and memory writes downstream.

Parameters:
PC_W, 10, program counter width in bits (instruction memory depth 2^PC_W)
CNT_W, 16, width of retired-instruction counter (optional feature only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  pulse: begin execution at start_addr (honoured in IDLE and DONE only)
start_addr  in  PC_W  first instruction address
halt  in  1  current instruction is the halt/done opcode (from decode)
branch_enable  in  1  control unit's resolved branch decision for current instruction
branch_target  in  PC_W  absolute target from branch LUT
mem_access  in  1  current instruction is a load or store (memRead|memWrite)
mem_ready  in  1  data memory completes access this cycle
pc  out  PC_W  address of current instruction
exec_en  out  1  current instruction executes this cycle; gates regWrite/memWrite
mem_stall  out  1  sequencer is waiting on mem_ready
done  out  1  program finished (level, held until next start)
pc_overflow  out  1  sticky: terminated by PC wrap, not halt
retired  out  CNT_W  retired-instruction count (zero when feature compiled out)

Behaviour:
- Reset (async, immediate): state=IDLE, pc=0, exec_en=0, mem_stall=0, done=0, pc_overflow=0, retired=0.
- States:
  - IDLE: outputs inactive; on start go to RUN with pc<=start_addr, pc_overflow<=0.
  - RUN: exec_en=1 (combinational from state).
  - MEM_WAIT: exec_en=0, mem_stall=1.
  - DONE: done=1, exec_en=0, pc held.
- RUN next-state priority (highest first):
  1. halt -> DONE, pc held; halt instruction counts as retired.
  2. mem_access & !mem_ready -> MEM_WAIT, pc held.
  3. branch_enable -> pc<=branch_target, stay RUN.
  4. Otherwise pc<=pc+1, stay RUN.
- Memory handshake: mem_access & mem_ready in the same RUN cycle is zero-wait; pc advances normally. Branch inputs are ignored on memory instructions.
- MEM_WAIT: hold until mem_ready=1, then pc<=pc+1 and return to RUN. The instruction retires in the cycle mem_ready is high. exec_en stays 0 in MEM_WAIT; the memory stage holds its request on mem_stall.
- Wrap-around: sequential increment from pc=2^PC_W-1 goes to DONE with pc_overflow=1 and pc held. A branch taken at max pc is legal and does not overflow.
- start is ignored in RUN and MEM_WAIT. A start in DONE restarts: done drops the next cycle and pc_overflow clears.
- Latency: start to first exec_en is 1 cycle. Throughput: 1 instruction/cycle without stalls.
- Reset mid-MEM_WAIT abandons the access; downstream must also reset.

Optional Feature:
FETCH_SEQ_RETIRE_COUNT_EN
- Defined:
  - retired increments on every retired instruction, including halt, and saturates at 2^CNT_W-1.
  - It clears on start accepted from IDLE/DONE and holds its value in DONE.
- Undefined: retired is tied to 0 and no counter flops exist.

Decomposition:
- Shared package (core_pkg): seq_state_t enum {IDLE, RUN, MEM_WAIT, DONE}; PC_W default constant.
- Sub-module: sat_counter (CNT_W, inc, clr, q), instantiated only under the macro.

Test Plan:
- Reset/start: start_addr=0x010, 3 plain instructions then halt -> pc 0x010,0x011,0x012,0x013; done=1 the cycle after halt; retired=4.
- Branch: at pc=0x005, branch_enable=1, branch_target=0x020 -> next pc=0x020; halt together with branch_enable -> DONE, pc stays 0x005.
- Memory stall: mem_access=1, mem_ready low 3 cycles -> mem_stall=1 and exec_en=0 for 3 cycles, pc held; mem_ready=1 -> pc+1; zero-wait case advances without stall.
- Overflow: start_addr=0x3FE, no branch/halt -> pc 0x3FE,0x3FF, then done=1, pc_overflow=1, pc=0x3FF.
- Start handling: start pulses during RUN ignored; start in DONE with start_addr=0x040 -> pc=0x040, done=0, pc_overflow cleared.
- Async reset asserted mid-MEM_WAIT, off clock edge -> all outputs 0 immediately, state IDLE.
